// File: rtl/color_mask_window_buffer_if.sv
// ---------------------------------------------------------------------------
// color_mask_window_buffer_if
//   Bundles the pixel input stream and the window output stream of
//   color_mask_window_buffer.
//
//   Parameters: M_SIZE (window side), COLORS (colour-mask bits per pixel).
//
//   Signals
//     in_valid       source -> block : pixel present
//     in_ready       block  -> source: pixel accepted this cycle if in_valid
//     in_sof         source -> block : pixel is (0,0) of a new frame
//     in_color_mask  source -> block : per-colour match bits
//     in_edge_data   source -> block : edge bit of the same pixel
//     out_window     block  -> sink  : M_SIZE x M_SIZE entries, bit COLORS is
//                                      the in-image flag, lower bits colours
//     out_edge_data  block  -> sink  : edge bit of the window centre
//     out_valid      block  -> sink  : window/edge valid this cycle
//     out_eof        block  -> sink  : with out_valid, centre is last pixel
//     dbg_state      block  -> sink  : current FSM state, for observation
//
//   Handshake: a pixel transfers on every rising clk edge where in_valid and
//   in_ready are both 1. in_ready does not depend on in_valid. The output
//   side has no back-pressure: out_valid is a one-cycle strobe and the sink
//   must take the window in that cycle.
//
//   Modports: master = pixel source / window sink, slave = the buffer.
// ---------------------------------------------------------------------------
interface color_mask_window_buffer_if #(
  parameter int M_SIZE = 11,
  parameter int COLORS = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [COLORS-1:0] in_color_mask;
  logic              in_edge_data;
  logic [COLORS:0]   out_window [0:M_SIZE-1][0:M_SIZE-1];
  logic              out_edge_data;
  logic              out_valid;
  logic              out_eof;
  logic [1:0]        dbg_state;

  modport master (
    output in_valid, in_sof, in_color_mask, in_edge_data,
    input  in_ready, out_window, out_edge_data, out_valid, out_eof, dbg_state
  );

  modport slave (
    input  in_valid, in_sof, in_color_mask, in_edge_data,
    output in_ready, out_window, out_edge_data, out_valid, out_eof, dbg_state
  );
endinterface

// File: rtl/color_mask_window_buffer.sv
// ---------------------------------------------------------------------------
// color_mask_window_buffer
//   Turns a raster stream of per-pixel colour-mask/edge bits into an
//   M_SIZE x M_SIZE neighbourhood window around a centre pixel that lags the
//   newest input by H rows and H columns (H = M_SIZE/2). Every window entry
//   carries an in-image flag derived from the centre coordinates; entries
//   outside the image (including rows wrapped across a row boundary) are
//   forced to zero.
//
//   Ports
//     clk    : sole clock, rising edge
//     reset  : asynchronous, active-high
//     bus    : color_mask_window_buffer_if.slave (pixel in, window out)
//
//   Optional feature macro: CMWB_FLUSH_EN
//     defined   -> after the last pixel of a frame, H*IMG_WIDTH+H bubble
//                  advances (in_ready low) push the tail of the frame out so
//                  every centre is emitted; the last carries out_eof.
//     undefined -> the frame ends with its last accepted pixel; the trailing
//                  H*IMG_WIDTH+H centres are never emitted.
// ---------------------------------------------------------------------------
module color_mask_window_buffer #(
  parameter int M_SIZE     = 11,
  parameter int COLORS     = 2,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clk,
  input  logic reset,
  color_mask_window_buffer_if.slave bus
);

  localparam int H   = M_SIZE / 2;
  localparam int LAG = H * IMG_WIDTH + H;
  localparam int PW  = COLORS + 1;
  localparam int CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LW  = $clog2(LAG + 1);

  localparam logic [CW-1:0] LAST_C = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_HEIGHT - 1);
  localparam logic [LW-1:0] LAG_V  = LW'(LAG);
  localparam logic [LW-1:0] LAG_M1 = LW'(LAG - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_FLUSH    = 2'd2,
    S_EOF_WAIT = 2'd3
  } state_t;

  state_t        state_q;
  logic [RW-1:0] in_r_q;    // raster position of the next accepted pixel
  logic [CW-1:0] in_c_q;
  logic [RW-1:0] cen_r_q;   // centre of the next advance once the lag is filled
  logic [CW-1:0] cen_c_q;
  logic [LW-1:0] fill_q;    // advances seen since sof, saturating at LAG
  logic [LW-1:0] flush_q;

  logic [PW-1:0] lb_q  [0:M_SIZE-2][0:IMG_WIDTH-1];
  logic [PW-1:0] win_q [0:M_SIZE-1][0:M_SIZE-1];

  logic [COLORS:0] out_win_q [0:M_SIZE-1][0:M_SIZE-1];
  logic            out_edge_q;
  logic            out_valid_q;
  logic            out_eof_q;

  // -------------------------------------------------------------------------
  // Advance control
  // -------------------------------------------------------------------------
  logic          in_ready;
  logic          accept;
  logic          start;
  logic          pix_adv;
  logic          bubble;
  logic          advance;
  logic [RW-1:0] pix_r;
  logic [CW-1:0] pix_c;
  logic [RW-1:0] nxt_r;
  logic [CW-1:0] nxt_c;
  logic [RW-1:0] cen_nxt_r;
  logic [CW-1:0] cen_nxt_c;
  logic          last_pix;
  logic          centre_ok;
  logic          centre_last;
  logic [PW-1:0] new_pix;

  assign in_ready = (state_q != S_FLUSH);
  assign accept   = bus.in_valid & in_ready;
  // sof restarts the frame from any accepting state, including mid-RUN.
  assign start    = accept & bus.in_sof;
  assign pix_adv  = start | (accept & (state_q == S_RUN));
  assign bubble   = (state_q == S_FLUSH);
  assign advance  = pix_adv | bubble;

  assign pix_r    = start ? '0 : in_r_q;
  assign pix_c    = start ? '0 : in_c_q;
  assign nxt_c    = (pix_c == LAST_C) ? '0 : pix_c + CW'(1);
  assign nxt_r    = (pix_c != LAST_C) ? pix_r :
                    (pix_r == LAST_R) ? '0 : pix_r + RW'(1);

  assign cen_nxt_c = (cen_c_q == LAST_C) ? '0 : cen_c_q + CW'(1);
  assign cen_nxt_r = (cen_c_q != LAST_C) ? cen_r_q :
                     (cen_r_q == LAST_R) ? '0 : cen_r_q + RW'(1);

  assign last_pix    = pix_adv & (pix_r == LAST_R) & (pix_c == LAST_C);
  // A sof advance is always the first of its frame, so it never has a centre.
  assign centre_ok   = advance & ~start & (fill_q == LAG_V);
  assign centre_last = (cen_r_q == LAST_R) & (cen_c_q == LAST_C);
  assign new_pix     = bubble ? '0 : {bus.in_edge_data, bus.in_color_mask};

  // -------------------------------------------------------------------------
  // Next window column and masked window
  // -------------------------------------------------------------------------
  logic [PW-1:0]   col_d      [0:M_SIZE-1];
  logic [PW-1:0]   win_d      [0:M_SIZE-1][0:M_SIZE-1];
  logic [COLORS:0] win_masked [0:M_SIZE-1][0:M_SIZE-1];

  always_comb begin
    for (int i = 0; i < M_SIZE - 1; i++) begin
      col_d[i] = lb_q[i][pix_c];
    end
    col_d[M_SIZE-1] = new_pix;

    for (int i = 0; i < M_SIZE; i++) begin
      for (int j = 0; j < M_SIZE - 1; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
      win_d[i][M_SIZE-1] = col_d[i];
    end
  end

  // Flags come only from the centre coordinates, so stale line-buffer data
  // from earlier frames or wrapped rows can never leak into the window.
  always_comb begin
    for (int i = 0; i < M_SIZE; i++) begin
      for (int j = 0; j < M_SIZE; j++) begin
        int rr;
        int cc;
        rr = int'(cen_r_q) - H + i;
        cc = int'(cen_c_q) - H + j;
        if (rr >= 0 && rr < IMG_HEIGHT && cc >= 0 && cc < IMG_WIDTH) begin
          win_masked[i][j] = {1'b1, win_d[i][j][COLORS-1:0]};
        end else begin
          win_masked[i][j] = '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage: line buffers and shift window (no reset needed; validity comes
  // from coordinates only)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (advance) begin
      win_q <= win_d;
      // Each column slot rotates one row older; the new pixel enters last.
      for (int k = 0; k < M_SIZE - 2; k++) begin
        lb_q[k][pix_c] <= lb_q[k+1][pix_c];
      end
      lb_q[M_SIZE-2][pix_c] <= new_pix;
    end
  end

  // -------------------------------------------------------------------------
  // FSM, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_r_q      <= '0;
      in_c_q      <= '0;
      cen_r_q     <= '0;
      cen_c_q     <= '0;
      fill_q      <= '0;
      flush_q     <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_edge_q  <= 1'b0;
      for (int i = 0; i < M_SIZE; i++) begin
        for (int j = 0; j < M_SIZE; j++) begin
          out_win_q[i][j] <= '0;
        end
      end
    end else begin
      out_valid_q <= centre_ok;
      out_eof_q   <= centre_ok & centre_last;
      if (centre_ok) begin
        out_win_q  <= win_masked;
        out_edge_q <= win_d[H][H][COLORS];
      end

      if (advance) begin
        in_r_q <= nxt_r;
        in_c_q <= nxt_c;
        if (start) begin
          fill_q  <= LW'(1);
          cen_r_q <= '0;
          cen_c_q <= '0;
        end else if (fill_q != LAG_V) begin
          fill_q <= fill_q + LW'(1);
        end else begin
          cen_r_q <= cen_nxt_r;
          cen_c_q <= cen_nxt_c;
        end
      end

      case (state_q)
        S_IDLE, S_EOF_WAIT: begin
          if (start) begin
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (last_pix) begin
`ifdef CMWB_FLUSH_EN
            state_q <= S_FLUSH;
            flush_q <= '0;
`else
            state_q <= S_IDLE;
`endif
          end
        end
        S_FLUSH: begin
          flush_q <= flush_q + LW'(1);
          if (flush_q == LAG_M1) begin
            state_q <= S_EOF_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_window    = out_win_q;
  assign bus.out_edge_data = out_edge_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_eof       = out_eof_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: doc/color_mask_window_buffer.md
COLOR_MASK_WINDOW_BUFFER -- requirements
Module: color_mask_window_buffer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  M_SIZE, 11, window side (odd, >=3); H = M_SIZE/2.
  COLORS, 2, colour-mask bits per pixel.
  IMG_WIDTH, 640, pixels per row.
  IMG_HEIGHT, 480, rows per frame.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  in_valid  in  1  input pixel present.
  in_ready  out  1  block accepts a pixel this cycle.
  in_sof  in  1  qualifies first pixel of a frame, (0,0).
  in_color_mask  in  COLORS  per-colour match bits.
  in_edge_data  in  1  edge-detector bit for the same pixel.
  out_window  out  [COLORS:0] x [0:M_SIZE-1][0:M_SIZE-1]  bit COLORS = in-image flag, bits COLORS-1:0 = colours.
  out_edge_data  out  1  edge bit of window centre pixel.
  out_valid  out  1  out_window/out_edge_data valid this cycle.
  out_eof  out  1  with out_valid: centre is (IMG_HEIGHT-1, IMG_WIDTH-1).

Function
REQ-003 Accept = in_valid & in_ready; pixels arrive in raster order; each accept (or flush bubble) is one "advance".
REQ-004 Storage: M_SIZE-1 line buffers of IMG_WIDTH entries, (COLORS+1) bits each (colours + edge), plus M_SIZE x M_SIZE shift window; one column shifts in per advance.
REQ-005 out_window[0][0] = oldest row, oldest column; out_window[H][H] = centre pixel.
REQ-006 Centre lags newest input by H rows and H columns: after advance of pixel (r,c), centre = raster position H*IMG_WIDTH+H earlier.
REQ-007 Each entry (i,j): flag = 1 iff (cr-H+i, cc-H+j) lies in [0,IMG_HEIGHT-1] x [0,IMG_WIDTH-1], computed from centre coordinates; if flag = 0, colour bits SHALL be 0 (rows wrapped across a row boundary are never flagged).
REQ-008 out_valid SHALL assert exactly one cycle after each advance whose centre lies inside the image; outputs are registered (latency 1 cycle after the advance).
REQ-009 out_edge_data = stored edge bit of centre pixel, aligned with out_window.
REQ-010 FSM states: IDLE (wait accept with in_sof), RUN (accepting), FLUSH, EOF_WAIT.
REQ-011 IDLE -> RUN on accept with in_sof; accepts without in_sof in IDLE are discarded, no output.
REQ-012 RUN -> FLUSH on accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-013 FLUSH: in_ready = 0; one bubble advance per cycle (colour/edge 0) for H*IMG_WIDTH+H cycles; then -> IDLE.
REQ-014 in_ready = 1 in IDLE and RUN, 0 in FLUSH.
REQ-015 Accept with in_sof while in RUN restarts: coordinates reset to (0,0), accepted pixel treated as (0,0), centre tracking restarts, pending outputs of aborted frame are never emitted.
REQ-016 in_valid gaps in RUN: no advance, window and outputs hold, out_valid = 0.
REQ-017 Coordinate counters wrap column IMG_WIDTH-1 -> 0 with row increment; widths $clog2 of dimension.

Reset
REQ-018 reset asserted: state = IDLE, counters = 0, out_valid = 0, out_eof = 0, out_edge_data = 0, out_window all 0, immediately (asynchronous).
REQ-019 Line buffer contents need not be cleared; validity derives solely from coordinates.
REQ-020 Reset mid-FLUSH or mid-RUN abandons the frame; first output after release requires a new in_sof frame.

Configuration
REQ-021 Macro CMWB_FLUSH_EN: defined -> FLUSH state per REQ-013, all IMG_WIDTH*IMG_HEIGHT centres emitted.
REQ-022 Undefined -> no FLUSH state; RUN -> IDLE after last pixel, in_ready never 0 after reset; last H*IMG_WIDTH+H centres never emitted, out_eof never asserts.

Verification (M_SIZE=3, COLORS=2, IMG_WIDTH=4, IMG_HEIGHT=4, CMWB_FLUSH_EN defined unless stated)
REQ-023 Reset, then 16 back-to-back pixels, in_sof on first, colour = pixel index[1:0] -> first out_valid one cycle after 6th accept, window[1][1] colours = 0, window[0][*] and window[*][0] flags = 0.
REQ-024 Centre (0,3) -> window[*][2] flags = 0 and colours 0 though buffer holds row-1 data; window[1][1] colours = 3.
REQ-025 After 16th accept -> in_ready = 0 for exactly 5 cycles, 5 further out_valid pulses, last with out_eof = 1, centre (3,3); 16 out_valid total.
REQ-026 in_valid toggled every other cycle -> out_valid pulses one per accepted pixel, outputs stable between; in_edge_data = 1 only on pixel (1,2) -> out_edge_data = 1 only with centre (1,2).
REQ-027 in_sof reasserted at 10th accept -> no centre of aborted frame after it; next output centre (0,0) after 6 accepts of new frame.
REQ-028 reset pulsed during FLUSH -> all outputs 0 same cycle, in_ready = 1 after release, no out_eof; CMWB_FLUSH_EN undefined -> 11 out_valid, in_ready never low.
